// File: rtl/wrr_pkg.sv
// Shared defaults and error-flag bit positions for the weighted round-robin client mux and its arbiter.
`default_nettype none

package wrr_pkg;

  localparam int DEF_CHANNELS = 8;
  localparam int DEF_DWIDTH   = 32;
  localparam int DEF_DEPTH    = 4;

  localparam int ERR_OVERFLOW  = 0;
  localparam int ERR_BAD_GRANT = 1;

endpackage

`default_nettype wire

// File: rtl/chan_fifo.sv
// Per-channel FIFO. The count is registered; a pop is honoured only when
// entries exist, and a push into a full FIFO is allowed when a pop happens in the same cycle.
`default_nettype none

module chan_fifo
  import wrr_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DWIDTH-1:0]      push_data,
  input  logic                   pop,
  output logic [DWIDTH-1:0]      head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

`default_nettype wire

// File: rtl/wrr_client_mux.sv
// Per-channel FIFOs feeding a weighted round-robin arbiter; the granted head is moved
// into a single output register, with sticky overflow and bad-grant flags.
`default_nettype none

module wrr_client_mux
  import wrr_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         push,
  input  logic [CHANNELS*DWIDTH-1:0]  push_data,
  output logic [CHANNELS-1:0]         full,
  output logic [CHANNELS-1:0]         request,
  input  logic [CHANNELS-1:0]         grant,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DWIDTH-1:0]           out_data,
  output logic [$clog2(CHANNELS)-1:0] out_channel,
  output logic [1:0]                  err
);

  localparam int CHW = $clog2(CHANNELS);
  localparam int CW  = $clog2(DEPTH) + 1;

  logic [DWIDTH-1:0]   head_w  [CHANNELS];
  logic [CW-1:0]       count_w [CHANNELS];
  logic [CHANNELS-1:0] pop_w;
  logic                grant_onehot_w, grant_hit_w, stage_free_w;
  logic                do_pop_w, bad_grant_w, overflow_w;
  logic [DWIDTH-1:0]   sel_data_w;
  logic [CHW-1:0]      sel_chan_w;

  logic                out_valid_q;
  logic [DWIDTH-1:0]   out_data_q;
  logic [CHW-1:0]      out_channel_q;
  logic [1:0]          err_q;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      chan_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push[i]),
        .push_data (push_data[i*DWIDTH +: DWIDTH]),
        .pop       (pop_w[i]),
        .head_data (head_w[i]),
        .count     (count_w[i])
      );
      assign request[i] = (count_w[i] != '0);
      assign full[i]    = (count_w[i] == CW'(DEPTH));
      assign pop_w[i]   = grant[i] & do_pop_w;
    end
  endgenerate

  assign stage_free_w   = !out_valid_q || out_ready;
  assign grant_onehot_w = (grant != '0) && ((grant & (grant - CHANNELS'(1))) == '0);
  assign grant_hit_w    = |(grant & request);
  assign do_pop_w       = grant_onehot_w && grant_hit_w && stage_free_w;
  assign bad_grant_w    = (grant != '0) && !(grant_onehot_w && grant_hit_w);
  // A full channel that is popped this cycle accepts its push, so it is not an overflow.
  assign overflow_w     = |(push & full & ~pop_w);

  always_comb begin
    sel_data_w = '0;
    sel_chan_w = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        sel_data_w = sel_data_w | head_w[i];
        sel_chan_w = sel_chan_w | CHW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      err_q         <= '0;
    end else begin
      if (stage_free_w) begin
        out_valid_q <= do_pop_w;
        if (do_pop_w) begin
          out_data_q    <= sel_data_w;
          out_channel_q <= sel_chan_w;
        end
      end
      if (overflow_w)  err_q[ERR_OVERFLOW]  <= 1'b1;
      if (bad_grant_w) err_q[ERR_BAD_GRANT] <= 1'b1;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_wrr_client_mux.sv
// Directed and randomized checks of wrr_client_mux against a queue-based reference model.
`default_nettype none

module tb_wrr_client_mux;

  localparam int CH = 8;
  localparam int DW = 32;
  localparam int DP = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   push, grant, full, request;
  logic [CH*DW-1:0] push_data;
  logic            out_valid, out_ready;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_channel;
  logic [1:0]      err;

  logic [DW-1:0]   mq [CH][$];
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic [2:0]      m_chan;
  logic [1:0]      m_err;

  int checks = 0;
  int failures = 0;

  wrr_client_mux #(.CHANNELS(CH), .DWIDTH(DW), .DEPTH(DP)) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_data   (push_data),
    .full        (full),
    .request     (request),
    .grant       (grant),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_channel (out_channel),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) mq[i].delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = '0;
    m_err   = '0;
  endtask

  task automatic check_model();
    logic [CH-1:0] exp_req, exp_full;
    for (int i = 0; i < CH; i++) begin
      exp_req[i]  = (mq[i].size() != 0);
      exp_full[i] = (mq[i].size() == DP);
    end
    chk("request", request, exp_req);
    chk("full", full, exp_full);
    chk("out_valid", out_valid, m_valid);
    chk("err", err, m_err);
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_channel", out_channel, m_chan);
    end
  endtask

  // One clock: check current state at the falling edge, advance the model, return at posedge+1.
  task automatic cycle();
    int ones, g;
    bit free, popped_f;
    logic [DW-1:0] popped;
    @(negedge clk);
    check_model();
    ones = 0;
    g = 0;
    for (int i = 0; i < CH; i++) if (grant[i]) begin ones++; g = i; end
    free = !m_valid || out_ready;
    if (ones > 1 || (ones == 1 && mq[g].size() == 0)) m_err[1] = 1'b1;
    popped_f = (ones == 1) && (mq[g].size() > 0) && free;
    popped = '0;
    if (popped_f) popped = mq[g].pop_front();
    for (int i = 0; i < CH; i++) begin
      if (push[i]) begin
        if (mq[i].size() < DP) mq[i].push_back(push_data[i*DW +: DW]);
        else m_err[0] = 1'b1;
      end
    end
    if (free) begin
      m_valid = popped_f;
      if (popped_f) begin
        m_data = popped;
        m_chan = 3'(g);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input int c, input logic [DW-1:0] d);
    push = '0;
    push[c] = 1'b1;
    push_data[c*DW +: DW] = d;
    cycle();
    push = '0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_request", request, 8'h00);
    chk("rst_full", full, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_chan", out_channel, 3'd0);
    chk("rst_err", err, 2'b00);
    model_reset();
    push = '0;
    grant = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int nonempty [$];
    logic [DW-1:0] first;
    reset = 1'b0;
    push = '0;
    grant = '0;
    push_data = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) cycle();
    chk("init_data", out_data, 32'h0);
    chk("init_chan", out_channel, 3'd0);
    reset = 1'b1;

    // Four beats on channel 2 drain back-to-back under a held grant.
    for (int k = 0; k < 4; k++) push1(2, 32'hA0 + k);
    chk("req2_set", request[2], 1'b1);
    grant = 8'h04;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("ch2_data", out_data, 32'hA0 + k);
      chk("ch2_chan", out_channel, 3'd2);
    end
    grant = '0;
    cycle();
    chk("ch2_idle_valid", out_valid, 1'b0);
    chk("ch2_idle_req", request[2], 1'b0);

    // Overflow on channel 0.
    for (int k = 0; k < 5; k++) begin
      push1(0, 32'hB0 + k);
      if (k == 3) chk("full0", full[0], 1'b1);
    end
    chk("ovf_err", err, 2'b01);

    // Grant order decides cross-channel order.
    push = 8'h22;
    push_data[1*DW +: DW] = 32'h11;
    push_data[5*DW +: DW] = 32'h55;
    cycle();
    push = '0;
    grant = 8'h20;
    cycle();
    chk("g5_data", out_data, 32'h55);
    chk("g5_chan", out_channel, 3'd5);
    grant = 8'h02;
    cycle();
    chk("g1_data", out_data, 32'h11);
    chk("g1_chan", out_channel, 3'd1);
    grant = '0;
    cycle();

    // Backpressure holds the output and channel 3 contents.
    push1(3, 32'h31);
    push1(3, 32'h32);
    push1(3, 32'h33);
    grant = 8'h08;
    cycle();
    first = out_data;
    chk("bp_first", first, 32'h31);
    out_ready = 1'b0;
    repeat (3) cycle();
    chk("bp_hold", out_data, 32'h31);
    chk("bp_req3", request[3], 1'b1);
    out_ready = 1'b1;
    cycle();
    chk("bp_d2", out_data, 32'h32);
    cycle();
    chk("bp_d3", out_data, 32'h33);
    grant = '0;
    cycle();

    // Bad grants, then reset mid-stream.
    grant = 8'h03;
    cycle();
    chk("bad_multi", err[1], 1'b1);
    chk("bad_nopop", full[0], 1'b1);
    grant = 8'h80;
    cycle();
    chk("bad_empty", err, 2'b11);
    grant = '0;
    cycle();
    do_reset();
    cycle();

    // Randomized traffic with a reset in the middle.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < CH; i++) push_data[i*DW +: DW] = $urandom;
      push = 8'($urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      nonempty.delete();
      for (int i = 0; i < CH; i++) if (mq[i].size() != 0) nonempty.push_back(i);
      case ($urandom_range(0, 19))
        0:       grant = 8'($urandom);
        1, 2, 3: grant = '0;
        default: grant = (nonempty.size() != 0) ?
                   (8'h01 << nonempty[$urandom_range(0, nonempty.size() - 1)]) : 8'h00;
      endcase
      cycle();
      if (n == 300) do_reset();
    end
    push = '0;
    grant = '0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
